// File: rtl/counter_access_arbiter_pkg.sv
// Shared types and constants for the counter access arbiter.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// when it is left undefined the arbiter uses fixed priority (lowest index wins).
package counter_arb_pkg;

  // Direction encoding used on grant_dir
  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  // Default sizing
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_N_CLIENTS = 4;

  // Width of a client index / rotation pointer (at least one bit)
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_N_CLIENTS);

  // IDLE: no grant pulse this cycle, GRANT: grant pulse this cycle
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/counter_access_arbiter_if.sv
// Client-side request bus and counter-side control bus of the arbiter.
// master: client/counter side, slave: the arbiter itself.
interface counter_access_arbiter_if import counter_arb_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_CLIENTS = DEF_N_CLIENTS
) ();

  logic                 en;
  logic [N_CLIENTS-1:0] inc_req;
  logic [N_CLIENTS-1:0] dec_req;
  logic [N_CLIENTS-1:0] grant;
  logic                 grant_dir;
  logic                 up;
  logic                 down;
  logic [WIDTH-1:0]     count;
  logic                 at_max;
  logic                 at_zero;

  modport master (
    output en, inc_req, dec_req,
    input  grant, grant_dir, up, down, count, at_max, at_zero
  );

  modport slave (
    input  en, inc_req, dec_req,
    output grant, grant_dir, up, down, count, at_max, at_zero
  );

endinterface

// File: rtl/counter_access_arbiter_rr_pick.sv
// Combinational picker: first eligible client at or after 'start',
// wrapping around to the clients below 'start'.
module rr_pick import counter_arb_pkg::*; #(
  parameter int N_CLIENTS = DEF_N_CLIENTS,
  parameter int PTR_W     = ptr_w(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] eligible,
  input  logic [PTR_W-1:0]     start,
  output logic [N_CLIENTS-1:0] winner,
  output logic [PTR_W-1:0]     win_idx,
  output logic                 found
);

  // Two passes: upper segment from start, then the wrapped lower segment
  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!found && eligible[i] && (i >= int'(start))) begin
        found     = 1'b1;
        winner[i] = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!found && eligible[i] && (i < int'(start))) begin
        found     = 1'b1;
        winner[i] = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/counter_access_arbiter.sv
// Arbitrates inc/dec requests from N_CLIENTS onto one external up/down
// counter, keeping a shadow count so the counter never leaves 0..MAX_CNT.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin (pointer follows the
// last winner); otherwise fixed priority with the lowest index winning.
module counter_access_arbiter import counter_arb_pkg::*; #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               N_CLIENTS = DEF_N_CLIENTS,
  parameter logic [WIDTH-1:0] MAX_CNT   = {WIDTH{1'b1}}
) (
  input logic                      clk,
  input logic                      reset,
  counter_access_arbiter_if.slave  bus
);

  localparam int PTR_W = ptr_w(N_CLIENTS);

  arb_state_e           state, state_nxt;
  logic [N_CLIENTS-1:0] grant_q, grant_nxt;
  logic                 dir_q, dir_nxt;
  logic [WIDTH-1:0]     count_q, count_nxt;

  logic [N_CLIENTS-1:0] eligible;
  logic [N_CLIENTS-1:0] winner;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     start;
  logic                 found;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  // A client competes only with a well-formed request whose bound is clear
  // and that was not granted this cycle (its request level is stale then).
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if ((bus.inc_req[i] ^ bus.dec_req[i]) && !grant_q[i]) begin
        if (bus.inc_req[i]) eligible[i] = (count_q != MAX_CNT);
        else                eligible[i] = (count_q != '0);
      end
    end
  end

  rr_pick #(
    .N_CLIENTS (N_CLIENTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .eligible (eligible),
    .start    (start),
    .winner   (winner),
    .win_idx  (win_idx),
    .found    (found)
  );

  // Next-state: register the winner, its direction, and move the shadow count
  always_comb begin
    state_nxt = ST_IDLE;
    grant_nxt = '0;
    dir_nxt   = DIR_DEC;
    count_nxt = count_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_nxt = rr_ptr;
`endif
    if (bus.en && found) begin
      state_nxt = ST_GRANT;
      grant_nxt = winner;
      dir_nxt   = bus.inc_req[win_idx] ? DIR_INC : DIR_DEC;
      if (bus.inc_req[win_idx]) count_nxt = count_q + 1'b1;
      else                      count_nxt = count_q - 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_nxt = (win_idx == PTR_W'(N_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
`endif
    end
  end

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      dir_q   <= DIR_DEC;
      count_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      dir_q   <= dir_nxt;
      count_q <= count_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr  <= rr_ptr_nxt;
`endif
    end
  end

  // up/down come straight from flops, so they are mutually exclusive pulses
  assign bus.grant     = grant_q;
  assign bus.grant_dir = dir_q;
  assign bus.up        = (state == ST_GRANT) && (dir_q == DIR_INC);
  assign bus.down      = (state == ST_GRANT) && (dir_q == DIR_DEC);
  assign bus.count     = count_q;
  assign bus.at_max    = (count_q == MAX_CNT);
  assign bus.at_zero   = (count_q == '0);

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench for counter_access_arbiter: one 8-bit instance for the
// main scenarios and one 3-bit instance for the upper bound.
module tb_counter_access_arbiter;
  import counter_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_access_arbiter_if #(.WIDTH(8), .N_CLIENTS(4)) bus8 ();
  counter_access_arbiter_if #(.WIDTH(3), .N_CLIENTS(4)) bus3 ();

  counter_access_arbiter #(.WIDTH(8), .N_CLIENTS(4)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  counter_access_arbiter #(.WIDTH(3), .N_CLIENTS(4), .MAX_CNT(3'd7)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  // Model of the external up/down counter fed by dut8
  logic [7:0] ext_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ext_cnt <= '0;
    else if (bus8.up)   ext_cnt <= ext_cnt + 8'd1;
    else if (bus8.down) ext_cnt <= ext_cnt - 8'd1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus8.inc_req = '0; bus8.dec_req = '0;
    bus3.inc_req = '0; bus3.dec_req = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  logic [3:0] exp_rot [5];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_rot = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
    bus8.en = 1'b1; bus8.inc_req = '0; bus8.dec_req = '0;
    bus3.en = 1'b1; bus3.inc_req = '0; bus3.dec_req = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_grant", 32'(bus8.grant), 32'h0);
    chk("rst_dir",   32'(bus8.grant_dir), 32'h0);
    chk("rst_up",    32'(bus8.up), 32'h0);
    chk("rst_down",  32'(bus8.down), 32'h0);
    chk("rst_count", 32'(bus8.count), 32'h0);
    chk("rst_zero",  32'(bus8.at_zero), 32'h1);
    tick();
    reset = 1'b1;

    // Single client: inc on client 2 for one cycle
    bus8.inc_req = 4'b0100;
    tick();
    chk("single_grant", 32'(bus8.grant), 32'h4);
    chk("single_up",    32'(bus8.up), 32'h1);
    chk("single_down",  32'(bus8.down), 32'h0);
    chk("single_dir",   32'(bus8.grant_dir), 32'h1);
    chk("single_count", 32'(bus8.count), 32'h1);
    chk("single_ext0",  32'(ext_cnt), 32'h0);
    bus8.inc_req = '0;
    tick();
    chk("single_idle",  32'(bus8.grant), 32'h0);
    chk("single_upoff", 32'(bus8.up), 32'h0);
    chk("single_ext1",  32'(ext_cnt), 32'h1);

    // Contention: all clients hold inc
    do_reset();
    bus8.inc_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rot_grant%0d", i), 32'(bus8.grant), 32'(exp_rot[i]));
      chk($sformatf("rot_up%0d", i),    32'(bus8.up), 32'h1);
    end
    chk("rot_count", 32'(bus8.count), 32'd5);
    bus8.inc_req = '0;
    tick();
    chk("rot_idle",  32'(bus8.grant), 32'h0);
    chk("rot_hold",  32'(bus8.count), 32'd5);
    chk("rot_ext",   32'(ext_cnt), 32'd5);

    // Lower bound: dec held at zero waits until an inc lifts the count
    do_reset();
    bus8.dec_req = 4'b0010;
    tick();
    chk("lo_nogrant0", 32'(bus8.grant), 32'h0);
    chk("lo_nodown",   32'(bus8.down), 32'h0);
    tick();
    chk("lo_nogrant1", 32'(bus8.grant), 32'h0);
    bus8.inc_req = 4'b1000;
    tick();
    chk("lo_inc_grant", 32'(bus8.grant), 32'h8);
    chk("lo_inc_count", 32'(bus8.count), 32'h1);
    bus8.inc_req = '0;
    tick();
    chk("lo_dec_grant", 32'(bus8.grant), 32'h2);
    chk("lo_dec_down",  32'(bus8.down), 32'h1);
    chk("lo_dec_up",    32'(bus8.up), 32'h0);
    chk("lo_dec_dir",   32'(bus8.grant_dir), 32'h0);
    bus8.dec_req = '0;
    tick();
    chk("lo_idle",  32'(bus8.grant), 32'h0);
    chk("lo_count", 32'(bus8.count), 32'h0);
    chk("lo_zero",  32'(bus8.at_zero), 32'h1);
    chk("lo_ext",   32'(ext_cnt), 32'h0);

    // Malformed request and enable gating
    do_reset();
    bus8.inc_req = 4'b0100;
    bus8.dec_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bad_grant%0d", i), 32'(bus8.grant), 32'h0);
    end
    chk("bad_count", 32'(bus8.count), 32'h0);
    bus8.inc_req = 4'b0001;
    bus8.dec_req = '0;
    bus8.en = 1'b0;
    tick();
    chk("en_off0", 32'(bus8.grant), 32'h0);
    tick();
    chk("en_off1", 32'(bus8.grant), 32'h0);
    bus8.en = 1'b1;
    tick();
    chk("en_on_grant", 32'(bus8.grant), 32'h1);
    chk("en_on_count", 32'(bus8.count), 32'h1);
    bus8.inc_req = '0;
    tick();

    // Asynchronous reset while client 1 holds a grant
    do_reset();
    bus8.inc_req = 4'b0010;
    tick();
    chk("ar_grant", 32'(bus8.grant), 32'h2);
    chk("ar_count", 32'(bus8.count), 32'h1);
    #3 reset = 1'b0;
    #1;
    chk("ar_grant_clr", 32'(bus8.grant), 32'h0);
    chk("ar_up_clr",    32'(bus8.up), 32'h0);
    chk("ar_count_clr", 32'(bus8.count), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("ar_regrant", 32'(bus8.grant), 32'h2);
    chk("ar_recount", 32'(bus8.count), 32'h1);
    bus8.inc_req = '0;
    tick();

    // Upper bound on the 3-bit instance
    do_reset();
    bus3.inc_req = 4'b0101;
    repeat (7) tick();
    chk("hi_count7", 32'(bus3.count), 32'd7);
    chk("hi_atmax",  32'(bus3.at_max), 32'h1);
    bus3.inc_req = 4'b0001;
    tick();
    chk("hi_block0", 32'(bus3.grant), 32'h0);
    tick();
    chk("hi_block1", 32'(bus3.grant), 32'h0);
    chk("hi_noup",   32'(bus3.up), 32'h0);
    bus3.dec_req = 4'b0010;
    tick();
    chk("hi_dec_grant", 32'(bus3.grant), 32'h2);
    chk("hi_dec_count", 32'(bus3.count), 32'd6);
    chk("hi_dec_down",  32'(bus3.down), 32'h1);
    bus3.dec_req = '0;
    tick();
    chk("hi_inc_grant", 32'(bus3.grant), 32'h1);
    chk("hi_inc_count", 32'(bus3.count), 32'd7);
    bus3.inc_req = '0;
    tick();
    chk("hi_idle",  32'(bus3.grant), 32'h0);
    chk("hi_max2",  32'(bus3.at_max), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
